// File: rtl/spt_steal_arb.sv
// spt_steal_arb
// Cycle-steal arbiter for serial-port autobuffer, host and BDMA memory
// transfers. Picks one of NCH requesting channels per cycle, and raises SREQ
// when the steal window is open. Consecutive steals are limited to MAX_BURST
// before one core cycle is given back.
//
// Ports:
//   DSPCLK        system clock
//   RST           asynchronous, active-high reset
//   GO_EX, STBY   core executing / standby: steal window open
//   HOLD          emulator halt; suppresses channels flagged in ICE_MASK
//   REQ[NCH]      per-channel level request, held until ACK
//   ICE_MASK[NCH] channel suppressed while HOLD=1
//   DIR[NCH]      1 = channel writes memory, 0 = channel reads memory
//   PM_SEL[NCH]   1 = channel targets PM, 0 = DM
//   CH_DATA       channel write data, channel i at [i*DW +: DW]
//   GNT[NCH]      one-hot combinational grant (not gated by SREQ)
//   ACK[NCH]      registered one-cycle service acknowledge
//   SREQ          steal request this cycle
//   STEAL         registered SREQ
//   DMS_WR/DMS_RD/PMS_WR/PMS_RD  memory cycle requests for the granted channel
//   DMD_OE, DMD_DO               DMD bus drive enable and data (0 when idle)
//
// Handshake: a channel holds REQ high until it sees ACK. ACK arrives exactly
// one clock after the SREQ cycle that granted it; the channel is ineligible
// in the ACK cycle, so it either drops REQ then or keeps it up for the next
// word and is considered again on the following cycle.
module spt_steal_arb #(
  parameter int NCH       = 6,
  parameter int DW        = 16,
  parameter int RR_EN     = 0,
  parameter int MAX_BURST = 4
) (
  input  logic              DSPCLK,
  input  logic              RST,
  input  logic              GO_EX,
  input  logic              STBY,
  input  logic              HOLD,
  input  logic [NCH-1:0]    REQ,
  input  logic [NCH-1:0]    ICE_MASK,
  input  logic [NCH-1:0]    DIR,
  input  logic [NCH-1:0]    PM_SEL,
  input  logic [NCH*DW-1:0] CH_DATA,
  output logic [NCH-1:0]    GNT,
  output logic [NCH-1:0]    ACK,
  output logic              SREQ,
  output logic              STEAL,
  output logic              DMS_WR,
  output logic              DMS_RD,
  output logic              PMS_WR,
  output logic              PMS_RD,
  output logic              DMD_OE,
  output logic [DW-1:0]     DMD_DO
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  logic [NCH-1:0] mreq;
  logic [NCH-1:0] g;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  gidx;
  logic [BW-1:0]  bcnt;
  logic           win;
  logic           gap;

  // Eligibility, steal window and burst gap.
  always_comb begin
    mreq = REQ & ~({NCH{HOLD}} & ICE_MASK) & ~ACK;
    win  = GO_EX | STBY | STEAL;
    gap  = (MAX_BURST != 0) && (bcnt == BW'(MAX_BURST));
    SREQ = win & ~gap & (|mreq);
  end

  // Priority scan. Fixed mode starts at channel 0; round-robin mode starts
  // at ptr and wraps, so the channel after the last grant is favoured.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    GNT   = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (RR_EN != 0) idx = PW'((int'(ptr) + k) % NCH);
      else            idx = PW'(k);
      if (!found && mreq[idx]) begin
        found    = 1'b1;
        GNT[idx] = 1'b1;
        gidx     = idx;
      end
    end
  end

  // Memory cycle requests and DMD drive for the granted channel.
  always_comb begin
    g      = {NCH{SREQ}} & GNT;
    DMS_WR = |(g &  DIR & ~PM_SEL);
    DMS_RD = |(g & ~DIR & ~PM_SEL);
    PMS_WR = |(g &  DIR &  PM_SEL);
    PMS_RD = |(g & ~DIR &  PM_SEL);
    DMD_OE = DMS_WR | PMS_WR;
    DMD_DO = '0;
    // g is one-hot or zero, so at most one slice is selected.
    for (int i = 0; i < NCH; i++) begin
      if (g[i] && DIR[i]) DMD_DO = CH_DATA[i*DW +: DW];
    end
  end

  always_ff @(posedge DSPCLK or posedge RST) begin
    if (RST) begin
      ACK   <= '0;
      STEAL <= 1'b0;
      bcnt  <= '0;
      ptr   <= '0;
    end else begin
      ACK   <= g;
      STEAL <= SREQ;
      // gap forces SREQ low at MAX_BURST, so bcnt never passes it.
      bcnt  <= SREQ ? bcnt + 1'b1 : '0;
      if ((RR_EN != 0) && (NCH > 1) && SREQ)
        ptr <= (gidx == PW'(NCH - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule
